// File: rtl/fifo_axis_pkg.sv
// Shared constants and types for the FIFO-to-AXIS read engine.
package fifo_axis_pkg;

    localparam int unsigned BUF_DEPTH          = 3;
    localparam int unsigned OCC_WIDTH          = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } axis_beat_t;

    // A new read may only be issued if the buffer can absorb it together with any in-flight word.
    function automatic logic has_room(input logic [OCC_WIDTH-1:0] occ, input logic inflight);
        return ({1'b0, occ} + {2'b00, inflight}) < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_axis_reader_if.sv
// FIFO read port plus AXI4-Stream master signals of the reader.
interface fifo_axis_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_rd_valid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        input  fifo_rd_valid,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        output fifo_rd_valid,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface

// File: rtl/axis_out_buf.sv
// Small in-order register buffer; head lives at entry 0 and entries shift down on pop.
module axis_out_buf
    import fifo_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [OCC_WIDTH-1:0]  o_occ
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [OCC_WIDTH-1:0]  occ_q;
    logic [OCC_WIDTH-1:0]  occ_d;
    logic                  do_pop;

    assign do_pop = i_pop && (occ_q != '0);

    always_comb begin
        mem_d = mem_q;
        occ_d = occ_q;
        if (do_pop) begin
            for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            occ_d = occ_q - 1'b1;
        end
        // Push lands behind whatever survives the pop, so push+pop keeps order and occupancy.
        if (i_push && (occ_d < OCC_WIDTH'(BUF_DEPTH))) begin
            mem_d[occ_d] = i_push_data;
            occ_d        = occ_d + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign o_head_data = mem_q[0];
    assign o_occ       = occ_q;

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a sync FIFO (1-cycle read latency) into an AXI4-Stream master with tlast every
// PACKET_LEN beats.
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH     = 8,
    parameter  int unsigned PACKET_LEN     = 16,
    localparam int unsigned BEAT_CNT_WIDTH = $clog2(PACKET_LEN) + 1
) (
    input  logic                       i_clk,
    input  logic                       i_s_rst_n,
    input  logic                       i_enable,
    fifo_axis_reader_if.master         m_bus,
    output logic                       o_pkt_done
);

    logic [OCC_WIDTH-1:0]      occ;
    logic [DATA_WIDTH-1:0]     head_data;
    logic                      inflight_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q;
    logic                      pkt_done_q;
    logic                      rd_en;
    logic                      tvalid;
    logic                      tlast;
    logic                      handshake;

    // Reset gating keeps the FIFO from being popped while the buffer cannot capture the word.
    assign rd_en     = i_s_rst_n && i_enable && !m_bus.fifo_empty && has_room(occ, inflight_q);
    assign tvalid    = (occ != '0);
    assign tlast     = tvalid && (beat_cnt_q == BEAT_CNT_WIDTH'(PACKET_LEN - 1));
    assign handshake = tvalid && m_bus.m_axis_tready;

    axis_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .i_clk       (i_clk),
        .i_s_rst_n   (i_s_rst_n),
        .i_push      (m_bus.fifo_rd_valid),
        .i_push_data (m_bus.fifo_rd_data),
        .i_pop       (handshake),
        .o_head_data (head_data),
        .o_occ       (occ)
    );

    always_ff @(posedge i_clk) begin
        if (!i_s_rst_n) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            if (rd_en) begin
                inflight_q <= 1'b1;
            end else if (m_bus.fifo_rd_valid) begin
                inflight_q <= 1'b0;
            end
            if (handshake) begin
                beat_cnt_q <= tlast ? '0 : beat_cnt_q + 1'b1;
            end
            pkt_done_q <= handshake && tlast;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_s_rst_n && m_bus.fifo_rd_valid && !inflight_q && (occ == OCC_WIDTH'(BUF_DEPTH))) begin
            $error("fifo_axis_reader: read data with full buffer and no read outstanding");
        end
    end
`endif

    assign m_bus.fifo_rd_en    = rd_en;
    assign m_bus.m_axis_tvalid = tvalid;
    assign m_bus.m_axis_tdata  = head_data;
    assign m_bus.m_axis_tlast  = tlast;
    assign o_pkt_done          = pkt_done_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench: behavioural sync FIFO feeding two readers (PACKET_LEN 16 and 4).
module tb_fifo_axis_reader;
    localparam int unsigned DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_a  = 1'b0;
    logic en_b  = 1'b0;
    logic done_a, done_b;
    int   checks = 0;
    int   errors = 0;

    fifo_axis_reader_if #(.DATA_WIDTH(DW)) bus_a ();
    fifo_axis_reader_if #(.DATA_WIDTH(DW)) bus_b ();

    fifo_axis_reader #(.DATA_WIDTH(DW), .PACKET_LEN(16)) dut_a (
        .i_clk(clk), .i_s_rst_n(rst_n), .i_enable(en_a), .m_bus(bus_a), .o_pkt_done(done_a)
    );
    fifo_axis_reader #(.DATA_WIDTH(DW), .PACKET_LEN(4)) dut_b (
        .i_clk(clk), .i_s_rst_n(rst_n), .i_enable(en_b), .m_bus(bus_b), .o_pkt_done(done_b)
    );

    always #5 clk = ~clk;

    // FIFO models: writes queued in wq_* become visible (empty drops) one edge later.
    logic [DW-1:0] fq_a[$], wq_a[$], fq_b[$], wq_b[$];
    always @(posedge clk) begin
        if (bus_a.fifo_rd_en && !bus_a.fifo_empty) begin
            bus_a.fifo_rd_data  <= fq_a.pop_front();
            bus_a.fifo_rd_valid <= 1'b1;
        end else bus_a.fifo_rd_valid <= 1'b0;
        while (wq_a.size() != 0) fq_a.push_back(wq_a.pop_front());
        bus_a.fifo_empty <= (fq_a.size() == 0);
    end
    always @(posedge clk) begin
        if (bus_b.fifo_rd_en && !bus_b.fifo_empty) begin
            bus_b.fifo_rd_data  <= fq_b.pop_front();
            bus_b.fifo_rd_valid <= 1'b1;
        end else bus_b.fifo_rd_valid <= 1'b0;
        while (wq_b.size() != 0) fq_b.push_back(wq_b.pop_front());
        bus_b.fifo_empty <= (fq_b.size() == 0);
    end

    // Stream monitors: capture beats and count protocol violations.
    int            rd_empty_err_a = 0, stab_err_a = 0, pkt_err_a = 0;
    logic          hold_a = 1'b0, prev_last_a = 1'b0, hold_l_a = 1'b0;
    logic [DW-1:0] hold_d_a = '0;
    logic [DW-1:0] cap_d_a[$], cap_d_b[$];
    logic          cap_l_a[$], cap_l_b[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_a      <= 1'b0;
            prev_last_a <= 1'b0;
        end else begin
            if (bus_a.fifo_rd_en && bus_a.fifo_empty) rd_empty_err_a <= rd_empty_err_a + 1;
            if (hold_a && (bus_a.m_axis_tvalid !== 1'b1 || bus_a.m_axis_tdata !== hold_d_a ||
                           bus_a.m_axis_tlast !== hold_l_a)) stab_err_a <= stab_err_a + 1;
            if (done_a !== prev_last_a) pkt_err_a <= pkt_err_a + 1;
            if (bus_a.m_axis_tvalid && bus_a.m_axis_tready) begin
                cap_d_a.push_back(bus_a.m_axis_tdata);
                cap_l_a.push_back(bus_a.m_axis_tlast);
            end
            hold_a      <= bus_a.m_axis_tvalid && !bus_a.m_axis_tready;
            hold_d_a    <= bus_a.m_axis_tdata;
            hold_l_a    <= bus_a.m_axis_tlast;
            prev_last_a <= bus_a.m_axis_tvalid && bus_a.m_axis_tready && bus_a.m_axis_tlast;
        end
    end
    always @(negedge clk) begin
        if (rst_n && bus_b.m_axis_tvalid && bus_b.m_axis_tready) begin
            cap_d_b.push_back(bus_b.m_axis_tdata);
            cap_l_b.push_back(bus_b.m_axis_tlast);
        end
    end

    task automatic drv(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); #2; endtask

    task automatic do_reset();
        drv();
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        bus_a.m_axis_tready = 1'b0; bus_b.m_axis_tready = 1'b0;
        fq_a.delete(); wq_a.delete(); fq_b.delete(); wq_b.delete();
        repeat (3) drv();
        cap_d_a.delete(); cap_l_a.delete(); cap_d_b.delete(); cap_l_b.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) drv();
        smp();
        checks++; if (bus_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", bus_a.fifo_rd_en); end
        checks++; if (bus_a.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", bus_a.m_axis_tvalid); end
        checks++; if (bus_a.m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", bus_a.m_axis_tdata); end
        checks++; if (bus_a.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", bus_a.m_axis_tlast); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got %b want 0", done_a); end
        checks++; if (dut_a.u_buf.occ_q !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", dut_a.u_buf.occ_q); end
        checks++; if (dut_a.inflight_q !== 1'b0) begin errors++; $display("FAIL reset_inflight got %b want 0", dut_a.inflight_q); end
        checks++; if (dut_a.beat_cnt_q !== '0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", dut_a.beat_cnt_q); end
        checks++; if (bus_b.m_axis_tvalid !== 1'b0 || bus_b.m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_b_outputs got valid=%b last=%b want 0 0", bus_b.m_axis_tvalid, bus_b.m_axis_tlast);
        end
    endtask

    task automatic test_stream();
        int bad_d = 0, bad_l = 0;
        do_reset();
        bus_a.m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) wq_a.push_back(DW'(i));
        drv(); drv();
        en_a = 1'b1;
        smp();
        checks++; if (bus_a.fifo_rd_en !== 1'b1 || bus_a.m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL stream_cycle0 got rd_en=%b tvalid=%b want 1 0", bus_a.fifo_rd_en, bus_a.m_axis_tvalid);
        end
        smp();
        checks++; if (bus_a.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL stream_cycle1 tvalid got %b want 0", bus_a.m_axis_tvalid); end
        smp();
        checks++; if (bus_a.m_axis_tvalid !== 1'b1 || bus_a.m_axis_tdata !== 8'h00) begin
            errors++; $display("FAIL stream_cycle2 got tvalid=%b tdata=%h want 1 00", bus_a.m_axis_tvalid, bus_a.m_axis_tdata);
        end
        for (int k = 0; k < 40 && cap_d_a.size() < 16; k++) smp();
        checks++; if (cap_d_a.size() != 16) begin errors++; $display("FAIL stream_count got %0d want 16", cap_d_a.size()); end
        for (int i = 0; i < cap_d_a.size(); i++) begin
            if (cap_d_a[i] !== DW'(i)) bad_d++;
            if (cap_l_a[i] !== (i == 15)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL stream_data got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL stream_tlast got %0d bad flags want 0", bad_l); end
        smp();
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL stream_pkt_done got %b want 1", done_a); end
        smp();
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL stream_pkt_done_pulse got %b want 0", done_a); end
        checks++; if (bus_a.fifo_empty !== 1'b1) begin errors++; $display("FAIL stream_fifo_empty got %b want 1", bus_a.fifo_empty); end
    endtask

    task automatic test_backpressure();
        int bad_d = 0, bad_l = 0, room_err = 0;
        int stab0, rde0;
        do_reset();
        stab0 = stab_err_a; rde0 = rd_empty_err_a;
        for (int i = 0; i < 20; i++) wq_a.push_back(DW'(8'h20 + i));
        en_a = 1'b1;
        for (int c = 0; c < 200 && cap_d_a.size() < 20; c++) begin
            bus_a.m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
            smp();
            if (int'(dut_a.u_buf.occ_q) + int'(dut_a.inflight_q) > 3) room_err++;
            drv();
        end
        checks++; if (cap_d_a.size() != 20) begin errors++; $display("FAIL bp_count got %0d want 20", cap_d_a.size()); end
        for (int i = 0; i < cap_d_a.size(); i++) begin
            if (cap_d_a[i] !== DW'(8'h20 + i)) bad_d++;
            if (cap_l_a[i] !== (i == 15)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL bp_data got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL bp_tlast got %0d bad flags want 0", bad_l); end
        checks++; if (stab_err_a != stab0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stab_err_a - stab0); end
        checks++; if (rd_empty_err_a != rde0) begin errors++; $display("FAIL bp_rd_empty got %0d violations want 0", rd_empty_err_a - rde0); end
        checks++; if (room_err != 0) begin errors++; $display("FAIL bp_occupancy got %0d overfills want 0", room_err); end
    endtask

    task automatic test_packet_wrap();
        int bad_d = 0, bad_l = 0;
        do_reset();
        bus_b.m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) wq_b.push_back(DW'(8'h40 + i));
        en_b = 1'b1;
        for (int k = 0; k < 60 && cap_d_b.size() < 10; k++) smp();
        checks++; if (cap_d_b.size() != 10) begin errors++; $display("FAIL wrap_count10 got %0d want 10", cap_d_b.size()); end
        for (int i = 0; i < cap_l_b.size(); i++) if (cap_l_b[i] !== (i == 3 || i == 7)) bad_l++;
        checks++; if (bad_l != 0) begin errors++; $display("FAIL wrap_tlast10 got %0d bad flags want 0", bad_l); end
        wq_b.push_back(8'h4A); wq_b.push_back(8'h4B);
        bad_l = 0;
        for (int k = 0; k < 60 && cap_d_b.size() < 12; k++) smp();
        checks++; if (cap_d_b.size() != 12) begin errors++; $display("FAIL wrap_count12 got %0d want 12", cap_d_b.size()); end
        for (int i = 0; i < cap_d_b.size(); i++) begin
            if (cap_d_b[i] !== DW'(8'h40 + i)) bad_d++;
            if (cap_l_b[i] !== (i % 4 == 3)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL wrap_data got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL wrap_tlast12 got %0d bad flags want 0", bad_l); end
    endtask

    task automatic test_enable_drop();
        int bad_d = 0, bad_l = 0, rd_hi = 0, n0, pkt0;
        do_reset();
        pkt0 = pkt_err_a;
        for (int i = 0; i < 16; i++) wq_a.push_back(DW'(8'h60 + i));
        bus_a.m_axis_tready = 1'b1;
        en_a = 1'b1;
        for (int k = 0; k < 60 && cap_d_a.size() < 6; k++) begin smp(); drv(); end
        en_a = 1'b0;
        smp();
        checks++; if (bus_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL en_drop_rd_en got %b want 0", bus_a.fifo_rd_en); end
        n0 = cap_d_a.size();
        for (int k = 0; k < 10; k++) begin smp(); if (bus_a.fifo_rd_en) rd_hi++; end
        checks++; if (rd_hi != 0) begin errors++; $display("FAIL en_drop_reads got %0d reads want 0", rd_hi); end
        checks++; if (cap_d_a.size() - n0 > 3) begin errors++; $display("FAIL en_drop_drain got %0d beats want <=3", cap_d_a.size() - n0); end
        drv();
        en_a = 1'b1;
        for (int k = 0; k < 60 && cap_d_a.size() < 16; k++) smp();
        smp();
        checks++; if (cap_d_a.size() != 16) begin errors++; $display("FAIL en_resume_count got %0d want 16", cap_d_a.size()); end
        for (int i = 0; i < cap_d_a.size(); i++) begin
            if (cap_d_a[i] !== DW'(8'h60 + i)) bad_d++;
            if (cap_l_a[i] !== (i == 15)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL en_resume_data got %0d bad words want 0", bad_d); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL en_resume_tlast got %0d bad flags want 0", bad_l); end
        checks++; if (pkt_err_a != pkt0) begin errors++; $display("FAIL en_pkt_done got %0d misplaced want 0", pkt_err_a - pkt0); end
    endtask

    task automatic test_underrun();
        int vcycles = 0, run = 0, maxrun = 0, bad_d = 0, rde0;
        do_reset();
        rde0 = rd_empty_err_a;
        bus_a.m_axis_tready = 1'b1;
        en_a = 1'b1;
        for (int w = 0; w < 6; w++) begin
            wq_a.push_back(DW'(8'h80 + w));
            repeat (5) begin
                smp();
                if (bus_a.m_axis_tvalid) begin
                    vcycles++; run++;
                    if (run > maxrun) maxrun = run;
                end else run = 0;
                drv();
            end
        end
        checks++; if (vcycles != 6) begin errors++; $display("FAIL underrun_valid_cycles got %0d want 6", vcycles); end
        checks++; if (maxrun != 1) begin errors++; $display("FAIL underrun_pulse_len got %0d want 1", maxrun); end
        for (int i = 0; i < cap_d_a.size(); i++) if (cap_d_a[i] !== DW'(8'h80 + i)) bad_d++;
        checks++; if (cap_d_a.size() != 6 || bad_d != 0) begin
            errors++; $display("FAIL underrun_data got %0d beats %0d bad want 6 0", cap_d_a.size(), bad_d);
        end
        checks++; if (rd_empty_err_a != rde0) begin errors++; $display("FAIL underrun_rd_empty got %0d want 0", rd_empty_err_a - rde0); end
    endtask

    task automatic test_reset_mid();
        int bad_d = 0, bad_l = 0;
        logic found = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) wq_a.push_back(DW'(8'hA0 + i));
        bus_a.m_axis_tready = 1'b1;
        en_a = 1'b1;
        for (int k = 0; k < 60 && cap_d_a.size() < 6; k++) begin smp(); drv(); end
        bus_a.m_axis_tready = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            smp();
            if (dut_a.u_buf.occ_q == 2'd2) found = 1'b1; else drv();
        end
        checks++; if (!found || bus_a.m_axis_tdata !== 8'hA6) begin
            errors++; $display("FAIL rstmid_setup got found=%b head=%h want 1 a6", found, bus_a.m_axis_tdata);
        end
        rst_n = 1'b0;
        smp();
        checks++; if (bus_a.m_axis_tvalid !== 1'b0 || dut_a.u_buf.occ_q !== 2'd0) begin
            errors++; $display("FAIL rstmid_clear got tvalid=%b occ=%0d want 0 0", bus_a.m_axis_tvalid, dut_a.u_buf.occ_q);
        end
        checks++; if (bus_a.m_axis_tdata !== 8'h00 || bus_a.m_axis_tlast !== 1'b0 || done_a !== 1'b0 || bus_a.fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got tdata=%h tlast=%b done=%b rd_en=%b want 00 0 0 0",
                               bus_a.m_axis_tdata, bus_a.m_axis_tlast, done_a, bus_a.fifo_rd_en);
        end
        drv();
        cap_d_a.delete(); cap_l_a.delete();
        for (int i = 0; i < 16; i++) wq_a.push_back(DW'(8'hB0 + i));
        bus_a.m_axis_tready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 80 && cap_d_a.size() < 16; k++) smp();
        checks++; if (cap_d_a.size() != 16) begin errors++; $display("FAIL rstmid_count got %0d want 16", cap_d_a.size()); end
        for (int i = 0; i < cap_d_a.size(); i++) begin
            if (cap_d_a[i] !== DW'(8'hA9 + i)) bad_d++;
            if (cap_l_a[i] !== (i == 15)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL rstmid_data got %0d bad words want 0 (first %h want a9)", bad_d, cap_d_a[0]); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL rstmid_tlast got %0d bad flags want 0", bad_l); end
    endtask

    initial begin
        bus_a.m_axis_tready = 1'b0;
        bus_b.m_axis_tready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_packet_wrap();
        test_enable_drop();
        test_underrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
